// File: rtl/computation_layer_ctrl.sv
// Iteration sequencer for one computation_layer_elem in multi-iteration mode.
// Optional watchdog in WAIT is enabled by defining COMPUTATION_LAYER_CTRL_TIMEOUT_EN.
module computation_layer_ctrl #(
  parameter int unsigned nIters     = 4,
  parameter int unsigned nCountBits = $clog2(nIters < 2 ? 2 : nIters),
  parameter int unsigned nmuxsels   = 1,
  parameter int unsigned tmo_cycles = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [nmuxsels-1:0]   mux_sel_in,
  input  logic                  layer_ready,
  output logic                  en_out,
  output logic [nCountBits-1:0] count_out,
  output logic [nmuxsels-1:0]   mux_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CountBitsReq = $clog2(nIters < 2 ? 2 : nIters);
  localparam logic [nCountBits-1:0] LastIter = nCountBits'(nIters - 1);

  if (nCountBits != CountBitsReq) begin : g_bad_count_bits
    $error("nCountBits is derived from nIters and must not be overridden");
  end
  if (nIters < 1) begin : g_bad_iters
    $error("nIters must be at least 1");
  end
  if (tmo_cycles < 1) begin : g_bad_tmo
    $error("tmo_cycles must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StIssue, StGuard, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [nCountBits-1:0] cnt_q, cnt_d;
  logic [nmuxsels-1:0]   mux_sel_q, mux_sel_d;
  logic                  en_q, busy_q, done_q;
  logic                  tmo_hit;

`ifdef COMPUTATION_LAYER_CTRL_TIMEOUT_EN
  localparam int unsigned WdBits = $clog2(tmo_cycles + 1);
  localparam logic [WdBits-1:0] WdLast = WdBits'(tmo_cycles - 1);

  logic [WdBits-1:0] wd_q, wd_d;
  logic              error_q;

  // Held at zero outside WAIT so every WAIT entry starts a fresh count.
  always_comb begin
    wd_d = '0;
    if (state_q == StWait && !layer_ready) begin
      wd_d = wd_q + WdBits'(1);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mux_sel_d = mux_sel_q;
    tmo_hit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StIssue;
          cnt_d     = '0;
          mux_sel_d = mux_sel_in;
        end
      end
      StIssue: state_d = StGuard;
      // Dead cycle: a stale ready from the previous iteration is ignored here.
      StGuard: state_d = StWait;
      StWait: begin
        if (layer_ready) begin
          if (cnt_q == LastIter) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + nCountBits'(1);
            state_d = StIssue;
          end
        end
`ifdef COMPUTATION_LAYER_CTRL_TIMEOUT_EN
        else if (wd_q == WdLast) begin
          state_d = StDone;
          tmo_hit = 1'b1;
        end
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mux_sel_q <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mux_sel_q <= mux_sel_d;
      en_q      <= (state_d == StIssue);
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StDone);
    end
  end

`ifdef COMPUTATION_LAYER_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= tmo_hit;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign en_out    = en_q;
  assign count_out = cnt_q;
  assign mux_sel   = mux_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_computation_layer_ctrl.sv
// Scoreboard bench for computation_layer_ctrl (nIters=4): directed runs, expected
// strobes/snapshots queued by the stimulus and checked by an independent monitor.
module tb_computation_layer_ctrl;

  localparam int unsigned NIters    = 4;
  localparam int unsigned TmoCycles = 8;

  logic       clk         = 1'b0;
  logic       rst         = 1'b1;
  logic       start       = 1'b0;
  logic [0:0] mux_sel_in  = 1'b0;
  logic       layer_ready = 1'b1;
  logic       en_out;
  logic [1:0] count_out;
  logic [0:0] mux_sel;
  logic       busy;
  logic       done;
  logic       error;

  computation_layer_ctrl #(
    .nIters     (NIters),
    .nmuxsels   (1),
    .tmo_cycles (TmoCycles)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mux_sel_in  (mux_sel_in),
    .layer_ready (layer_ready),
    .en_out      (en_out),
    .count_out   (count_out),
    .mux_sel     (mux_sel),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       en;
    logic       dn;
    logic       busy;
    logic       err;
    logic       msel;
    logic [1:0] cnt;
  } exp_t;

  exp_t ev_q[$];
  exp_t snap_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rdy_mode = 0;  // 0: ready tied 1, 1: layer model, 2: ready held 0
  int   last_en  = -100;

  always @(posedge clk) cyc <= cyc + 1;

  // Layer model: ready drops the cycle after en and comes back 5 cycles later.
  always @(negedge clk) begin
    if (en_out === 1'b1) last_en <= cyc;
    case (rdy_mode)
      0:       layer_ready <= 1'b1;
      1:       layer_ready <= !((cyc > last_en) && (cyc < last_en + 6));
      default: layer_ready <= 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, ".en_out"},    8'(en_out),    8'(e.en));
    chk({tag, ".done"},      8'(done),      8'(e.dn));
    chk({tag, ".busy"},      8'(busy),      8'(e.busy));
    chk({tag, ".error"},     8'(error),     8'(e.err));
    chk({tag, ".mux_sel"},   8'(mux_sel),   8'(e.msel));
    chk({tag, ".count_out"}, 8'(count_out), 8'(e.cnt));
  endtask

  // Monitor: pops expectations when the DUT strobes, or at scheduled snapshot cycles.
  always @(negedge clk) begin
    exp_t e;
    while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
      chk("event_seen", 8'd0, 8'd1);
      void'(ev_q.pop_front());
    end
    if (en_out === 1'b1 || done === 1'b1) begin
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        e = ev_q.pop_front();
        cmp_all("event", e);
      end else begin
        chk("unexpected_event", 8'd1, 8'd0);
      end
    end
    while (snap_q.size() > 0 && snap_q[0].cyc < cyc) begin
      chk("snapshot_reached", 8'd0, 8'd1);
      void'(snap_q.pop_front());
    end
    if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
      e = snap_q.pop_front();
      cmp_all("snapshot", e);
    end
  end

  task automatic push_ev(input int c, input logic en, input logic dn, input logic [1:0] cnt,
                         input logic msel, input logic err);
    exp_t e;
    e.cyc = c; e.en = en; e.dn = dn; e.busy = 1'b1; e.err = err; e.msel = msel; e.cnt = cnt;
    ev_q.push_back(e);
  endtask

  task automatic push_snap(input int c, input logic busy_e, input logic [1:0] cnt,
                           input logic msel, input logic err);
    exp_t e;
    e.cyc = c; e.en = 1'b0; e.dn = 1'b0; e.busy = busy_e; e.err = err; e.msel = msel;
    e.cnt = cnt;
    snap_q.push_back(e);
  endtask

  // Four strobes three cycles apart then done, for ready tied high.
  task automatic push_fast_run(input int t0, input logic msel);
    for (int i = 0; i < 4; i++) push_ev(t0 + 1 + 3 * i, 1'b1, 1'b0, 2'(i), msel, 1'b0);
    push_ev(t0 + 13, 1'b0, 1'b1, 2'd3, msel, 1'b0);
  endtask

  task automatic wait_drain(input bit toggle);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (toggle) mux_sel_in = ~mux_sel_in;
      if (ev_q.size() == 0 && snap_q.size() == 0) break;
    end
  endtask

  int t0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push_snap(cyc + 1, 1'b0, 2'd0, 1'b0, 1'b0);
    push_snap(cyc + 2, 1'b0, 2'd0, 1'b0, 1'b0);
    wait_drain(1'b0);

    // Ready tied high, mux_sel_in toggling after capture
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    t0 = cyc; mux_sel_in = 1'b1; start = 1'b1;
    push_fast_run(t0, 1'b1);
    push_snap(t0 + 5, 1'b1, 2'd1, 1'b1, 1'b0);
    push_snap(t0 + 14, 1'b0, 2'd3, 1'b1, 1'b0);
    @(negedge clk); start = 1'b0;
    wait_drain(1'b1);

    // Layer model with delayed ready, new mux select 0
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    t0 = cyc; mux_sel_in = 1'b0; start = 1'b1;
    for (int i = 0; i < 4; i++) push_ev(t0 + 1 + 7 * i, 1'b1, 1'b0, 2'(i), 1'b0, 1'b0);
    push_ev(t0 + 29, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    push_snap(t0 + 7, 1'b1, 2'd0, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    wait_drain(1'b0);

    // Reset during WAIT of iteration 2
    repeat (8) @(negedge clk);
    t0 = cyc; mux_sel_in = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) push_ev(t0 + 1 + 7 * i, 1'b1, 1'b0, 2'(i), 1'b1, 1'b0);
    push_snap(t0 + 19, 1'b0, 2'd0, 1'b0, 1'b0);
    push_snap(t0 + 20, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 40 && cyc < t0 + 18; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wait_drain(1'b0);

    // Start held high across two runs
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    t0 = cyc; mux_sel_in = 1'b0; start = 1'b1;
    push_fast_run(t0, 1'b0);
    push_snap(t0 + 14, 1'b0, 2'd3, 1'b0, 1'b0);
    push_fast_run(t0 + 14, 1'b0);
    for (int i = 0; i < 40 && cyc < t0 + 16; i++) @(negedge clk);
    start = 1'b0;
    wait_drain(1'b0);

`ifdef COMPUTATION_LAYER_CTRL_TIMEOUT_EN
    // Watchdog expiry with ready held low
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    t0 = cyc; mux_sel_in = 1'b1; start = 1'b1;
    push_ev(t0 + 1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    push_ev(t0 + 11, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
    push_snap(t0 + 10, 1'b1, 2'd0, 1'b1, 1'b0);
    push_snap(t0 + 12, 1'b0, 2'd0, 1'b1, 1'b0);
    @(negedge clk); start = 1'b0;
    wait_drain(1'b0);
    rdy_mode = 0;
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
